// File: rtl/riscv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// riscv_muldiv_unit : iterative RV32/64 M-extension multiply/divide, 1 bit/cycle.
// Divider datapath is present only when RISCV_MULDIV_DIV_EN is defined.
// Rev 1.0
// ============================================================================
module riscv_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_f3;
  logic              r_neg;
  logic [XLEN-1:0]   r_opb;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;

  logic              w_accept, w_special, w_calc_end;
  logic [XLEN-1:0]   w_special_res;
  logic              w_sa, w_sb, w_neg;
  logic [XLEN-1:0]   w_mag_a, w_mag_b;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_step, w_prod;
  logic [XLEN-1:0]   w_res_final;
`ifdef RISCV_MULDIV_DIV_EN
  logic              r_is_div;
  logic [XLEN+1:0]   w_trial;
  logic [XLEN-1:0]   w_half;
`endif

  assign w_calc_end = (r_cnt == CNT_W'(XLEN));
  assign result     = r_result;

  // Operands are reduced to magnitudes; the sign is reapplied at the end.
  assign w_sa    = op_a[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                                   (funct3 == 3'b100) | (funct3 == 3'b110));
  assign w_sb    = op_b[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b100) |
                                   (funct3 == 3'b110));
  assign w_mag_a = w_sa ? ('0 - op_a) : op_a;
  assign w_mag_b = w_sb ? ('0 - op_b) : op_b;
  assign w_neg   = (funct3[2] & funct3[1]) ? w_sa : (w_sa ^ w_sb);

  always_comb begin
    w_special     = 1'b0;
    w_special_res = '0;
`ifdef RISCV_MULDIV_DIV_EN
    if (funct3[2] && (op_b == '0)) begin
      w_special     = 1'b1;
      w_special_res = funct3[1] ? op_a : '1;
    end else if (funct3[2] && !funct3[0] &&
                 (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1)) begin
      w_special     = 1'b1;
      w_special_res = funct3[1] ? '0 : op_a;
    end
`else
    if (funct3[2]) begin
      w_special     = 1'b1;
      w_special_res = '0;
    end
`endif
  end

  // r_acc = {high/remainder, low/multiplier-or-quotient}
  always_comb begin
    w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    w_step = {w_sum, r_acc[XLEN-1:1]};
    w_prod = r_neg ? ('0 - r_acc) : r_acc;
    w_res_final = (r_f3 == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
`ifdef RISCV_MULDIV_DIV_EN
    w_trial = {1'b0, r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]} - {2'b00, r_opb};
    w_half  = r_f3[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
    if (r_is_div) begin
      if (w_trial[XLEN+1]) begin
        w_step = {r_acc[2*XLEN-2:0], 1'b0};
      end else begin
        w_step = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end
      w_res_final = r_neg ? ('0 - w_half) : w_half;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_special ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (w_calc_end) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_f3     <= '0;
      r_neg    <= 1'b0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_result <= '0;
`ifdef RISCV_MULDIV_DIV_EN
      r_is_div <= 1'b0;
`endif
    end else if (w_accept) begin
      r_cnt <= '0;
      r_f3  <= funct3[1:0];
      r_neg <= w_neg;
      r_opb <= w_mag_b;
      r_acc <= {{XLEN{1'b0}}, w_mag_a};
`ifdef RISCV_MULDIV_DIV_EN
      r_is_div <= funct3[2];
`endif
      if (w_special) begin
        r_result <= w_special_res;
      end
    end else if (r_state == S_CALC) begin
      if (w_calc_end) begin
        r_result <= w_res_final;
      end else begin
        r_acc <= w_step;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_riscv_muldiv_unit : directed-vector bench for riscv_muldiv_unit (XLEN=32).
// Rev 1.0
// ============================================================================
module tb_riscv_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  riscv_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a request for one edge (edge k), then scramble the inputs.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; funct3 = 3'b101; op_a = 32'hDEADBEEF; op_b = 32'h0;
  endtask

  // Edges after edge k until out_valid is seen; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic consume();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({in_ready, out_valid, busy, result} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b res=%h want 1 0 0 0",
               in_ready, out_valid, busy, result);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_mul_timing();
    int lat;
    issue(3'b000, 32'd7, 32'hFFFFFFFD);
    tests_run++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL mul_calc_flags: got busy=%b rdy=%b want 1 0", busy, in_ready);
    end
    wait_valid(lat);
    tests_run++;
    if (lat !== 33) begin
      tests_failed++;
      $display("FAIL mul_latency: got %0d want 33", lat);
    end
    tests_run++;
    if (result !== 32'hFFFFFFEB) begin
      tests_failed++;
      $display("FAIL mul_7x-3: got %h want ffffffeb", result);
    end
    consume();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mul_after_handshake: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_mul_vectors();
    logic [2:0]  f  [8] = '{3'b001, 3'b011, 3'b010, 3'b001, 3'b001, 3'b011, 3'b000, 3'b010};
    logic [31:0] a  [8] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'd7, 32'h80000000, 32'h00010000, 32'd2};
    logic [31:0] b  [8] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'hFFFFFFFD, 32'd4, 32'h00010000, 32'h80000000};
    logic [31:0] ex [8] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000,
                            32'hFFFFFFFF, 32'h00000002, 32'h00000000, 32'h00000001};
    int lat;
    for (int i = 0; i < 8; i++) begin
      issue(f[i], a[i], b[i]);
      wait_valid(lat);
      tests_run++;
      if (lat !== 33 || result !== ex[i]) begin
        tests_failed++;
        $display("FAIL mul_vec%0d: got lat=%0d res=%h want lat=33 res=%h", i, lat, result, ex[i]);
      end
      consume();
    end
  endtask

`ifdef RISCV_MULDIV_DIV_EN
  task automatic test_div_vectors();
    logic [2:0]  f  [6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] a  [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd7, 32'd7};
    logic [31:0] b  [6] = '{32'd2, 32'd2, 32'd2, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
    logic [31:0] ex [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'd2,
                            32'hFFFFFFFD, 32'd1};
    int lat;
    for (int i = 0; i < 6; i++) begin
      issue(f[i], a[i], b[i]);
      wait_valid(lat);
      tests_run++;
      if (lat !== 33 || result !== ex[i]) begin
        tests_failed++;
        $display("FAIL div_vec%0d: got lat=%0d res=%h want lat=33 res=%h", i, lat, result, ex[i]);
      end
      consume();
    end
  endtask

  task automatic test_div_special();
    logic [2:0]  f  [5] = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b111};
    logic [31:0] a  [5] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd9};
    logic [31:0] b  [5] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    logic [31:0] ex [5] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'd9};
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue(f[i], a[i], b[i]);
      #0;
      tests_run++;
      if (out_valid !== 1'b1 || result !== ex[i]) begin
        tests_failed++;
        $display("FAIL div_special%0d: got vld=%b res=%h want vld=1 res=%h", i, out_valid, result, ex[i]);
      end
      consume();
    end
  endtask
`else
  task automatic test_div_disabled();
    int lat;
    issue(3'b100, 32'd10, 32'd2);
    tests_run++;
    if (out_valid !== 1'b1 || result !== 32'd0) begin
      tests_failed++;
      $display("FAIL div_disabled: got vld=%b res=%h want vld=1 res=0", out_valid, result);
    end
    consume();
    issue(3'b000, 32'd10, 32'd2);
    wait_valid(lat);
    tests_run++;
    if (lat !== 33 || result !== 32'd20) begin
      tests_failed++;
      $display("FAIL mul_with_div_off: got lat=%0d res=%h want lat=33 res=14", lat, result);
    end
    consume();
  endtask
`endif

  task automatic test_backpressure_and_reset();
    int lat;
    logic [31:0] held;
    out_ready = 1'b0;
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_valid(lat);
    held = result;
    tests_run++;
    if (lat !== 33 || held !== 32'hFFFFFFFE) begin
      tests_failed++;
      $display("FAIL stall_first: got lat=%0d res=%h want lat=33 res=fffffffe", lat, held);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== held) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: got vld=%b rdy=%b res=%h want 1 0 %h",
                 i, out_valid, in_ready, result, held);
      end
    end
    out_ready = 1'b1;
    consume();
    issue(3'b000, 32'd3, 32'd4);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({in_ready, out_valid, busy, result} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_mid_calc: got rdy=%b vld=%b busy=%b res=%h want 1 0 0 0",
               in_ready, out_valid, busy, result);
    end
    @(negedge clk) rst = 1'b0;
    wait_valid(lat);
    tests_run++;
    if (lat !== -1 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_abort: got lat=%0d rdy=%b want lat=-1 rdy=1", lat, in_ready);
    end
    issue(3'b000, 32'd3, 32'd4);
    wait_valid(lat);
    tests_run++;
    if (lat !== 33 || result !== 32'd12) begin
      tests_failed++;
      $display("FAIL post_reset_mul: got lat=%0d res=%h want lat=33 res=c", lat, result);
    end
    consume();
  endtask

  // Next request held on the bus from the DONE cycle on; acceptance must wait
  // for the cycle after the handshake.
  task automatic test_back_to_back();
    int lat;
    int gap;
    issue(3'b000, 32'd6, 32'd7);
    wait_valid(lat);
    tests_run++;
    if (lat !== 33 || result !== 32'd42) begin
      tests_failed++;
      $display("FAIL b2b_first: got lat=%0d res=%h want lat=33 res=2a", lat, result);
    end
    funct3 = 3'b000; op_a = 32'd5; op_b = 32'd9; in_valid = 1'b1;
    gap = -1;
    for (int n = 1; n <= 3; n++) begin
      @(posedge clk); #1;
      if (busy) begin
        gap = n;
        break;
      end
    end
    in_valid = 1'b0; op_a = 32'hDEADBEEF;
    tests_run++;
    if (gap !== 2) begin
      tests_failed++;
      $display("FAIL b2b_accept_edge: got %0d edges after DONE want 2", gap);
    end
    wait_valid(lat);
    tests_run++;
    if (lat !== 33 || result !== 32'd45) begin
      tests_failed++;
      $display("FAIL b2b_second: got lat=%0d res=%h want lat=33 res=2d", lat, result);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_mul_vectors();
`ifdef RISCV_MULDIV_DIV_EN
    test_div_vectors();
    test_div_special();
`else
    test_div_disabled();
`endif
    test_backpressure_and_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_muldiv_unit.md
RISCV_MULDIV_UNIT -- requirements
Module: riscv_muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 8..64, even only.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit, request present.
REQ-005 SHALL have port in_ready, output, 1 bit, unit can accept a request.
REQ-006 SHALL have port funct3, input, 3 bits, RV M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port op_a, input, XLEN bits, rs1 value (multiplicand/dividend).
REQ-008 SHALL have port op_b, input, XLEN bits, rs2 value (multiplier/divisor).
REQ-009 SHALL have port out_valid, output, 1 bit, result available.
REQ-010 SHALL have port out_ready, input, 1 bit, consumer accepts result.
REQ-011 SHALL have port result, output, XLEN bits, operation result.
REQ-012 SHALL have port busy, output, 1 bit, high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 SHALL capture funct3, op_a and op_b on the edge where in_valid && in_ready (edge k); inputs are ignored at all other times.
REQ-015 SHALL compute MUL/DIV iteratively at 1 bit per cycle: CALC lasts exactly XLEN cycles; out_valid rises at edge k+XLEN+1.
REQ-016 SHALL return, for MUL, low XLEN bits of the product; for MULH/MULHSU/MULHU, high XLEN bits with signed x signed, signed x unsigned and unsigned x unsigned operands respectively.
REQ-017 SHALL use signed operands for DIV/REM, rounding the quotient toward zero; the remainder takes the dividend's sign.
REQ-018 SHALL handle divide-by-zero by going directly IDLE -> DONE (out_valid at edge k+1): DIV/DIVU result all-ones; REM/REMU result op_a.
REQ-019 SHALL handle signed overflow (op_a = most-negative, op_b = -1) by going IDLE -> DONE at edge k+1: DIV result op_a; REM result 0.
REQ-020 SHALL hold result and out_valid stable in DONE until out_ready = 1; on that edge it SHALL return to IDLE and drop out_valid.
REQ-021 SHALL NOT accept a new request in the same cycle as the DONE handshake; the earliest next acceptance is the following cycle.
REQ-022 SHALL keep result at its last value in IDLE and CALC; it is only meaningful while out_valid = 1.

Reset
REQ-023 SHALL, on rst = 1 at any time including mid-CALC or in DONE, abort the operation and force state IDLE, in_ready 1, out_valid 0, busy 0, result 0 and all internal registers 0.
REQ-024 SHALL act on the first rising clk edge after rst deasserts (in_ready already 1).

Configuration
REQ-025 SHALL compile the divide datapath only when macro RISCV_MULDIV_DIV_EN is defined.
REQ-026 SHALL, with RISCV_MULDIV_DIV_EN defined, implement REQ-017..REQ-019 fully.
REQ-027 SHALL, without RISCV_MULDIV_DIV_EN, treat funct3[2] = 1 as unsupported: go IDLE -> DONE at edge k+1 with result 0; multiply ops are unchanged; no divider logic is synthesised.

Verification (XLEN = 32, RISCV_MULDIV_DIV_EN defined unless noted)
REQ-028 SHALL cover MUL 7 x -3 with out_ready held 1 -> result 0xFFFFFFEB; out_valid high only at edge k+33; in_ready high again at k+34.
REQ-029 SHALL cover MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-030 SHALL cover DIV -7 / 2 -> 0xFFFFFFFD, and REM -7 % 2 -> 0xFFFFFFFF, each with 32-cycle CALC.
REQ-031 SHALL cover DIVU 5 / 0 -> 0xFFFFFFFF, REM 5 % 0 -> 5, and DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, each with out_valid at k+1.
REQ-032 SHALL cover out_ready held 0 for 10 cycles in DONE -> result/out_valid stable, in_ready 0; then rst pulsed at CALC cycle 5 of a new op -> out_valid never rises, in_ready 1 next cycle.
REQ-033 SHALL cover, without RISCV_MULDIV_DIV_EN, DIV 10 / 2 -> result 0 at k+1, while MUL 10 x 2 -> 20 at k+33.
